// File: rtl/snn_axi4l_image_loader.sv
// snn_axi4l_image_loader
//   AXI4-Lite slave that loads packed-pixel images into a ping-pong image
//   store and hands the completed bank to the SNN core. It also returns the
//   inferred digit through a STATUS/RESULT register pair.
// Ports:
//   CLK, RST                : clock, asynchronous active-high reset
//   AW*/W*/B*               : AXI4-Lite write channels (image window + CTRL/STATUS)
//   AR*/R*                  : AXI4-Lite read channels (CTRL/STATUS/RESULT)
//   IMAGE_FLAT/VALID/READY  : core-side bank and its handshake
//   RESULT_IN_VALID,
//   INFERED_DIGIT           : one-cycle result pulse and value from the core
//   IRQ                     : level interrupt, IRQ_EN & (RES_VALID | OVERRUN)
module snn_axi4l_image_loader #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int IMAGE_SIZE     = 256,
  parameter int PIXEL_BITS     = 8,
  parameter int RESULT_BITS    = 8,
  parameter int REG_BASE       = 4096
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [AXI_ADDR_WIDTH-1:0]            AWADDR,
  input  logic                                 AWVALID,
  output logic                                 AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]            WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]          WSTRB,
  input  logic                                 WVALID,
  output logic                                 WREADY,
  output logic [1:0]                           BRESP,
  output logic                                 BVALID,
  input  logic                                 BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]            ARADDR,
  input  logic                                 ARVALID,
  output logic                                 ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]            RDATA,
  output logic [1:0]                           RRESP,
  output logic                                 RVALID,
  input  logic                                 RREADY,
  output logic [IMAGE_SIZE*PIXEL_BITS-1:0]     IMAGE_FLAT,
  output logic                                 IMAGE_VALID,
  input  logic                                 IMAGE_READY,
  input  logic                                 RESULT_IN_VALID,
  input  logic [RESULT_BITS-1:0]               INFERED_DIGIT,
  output logic                                 IRQ
);

  localparam int PPW     = AXI_DATA_WIDTH / PIXEL_BITS;
  localparam int WORDS   = IMAGE_SIZE / PPW;
  localparam int BPW     = AXI_DATA_WIDTH / 8;
  localparam int SPP     = PIXEL_BITS / 8;  // byte strobes per pixel
  localparam int IMG_W   = IMAGE_SIZE * PIXEL_BITS;
  localparam int BPW_LOG = $clog2(BPW);
  localparam int WIDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [AXI_ADDR_WIDTH-1:0] IMG_END     = AXI_ADDR_WIDTH'(WORDS * BPW);
  localparam logic [AXI_ADDR_WIDTH-1:0] CTRL_ADDR   = AXI_ADDR_WIDTH'(REG_BASE);
  localparam logic [AXI_ADDR_WIDTH-1:0] STATUS_ADDR = AXI_ADDR_WIDTH'(REG_BASE + 4);
  localparam logic [AXI_ADDR_WIDTH-1:0] RESULT_ADDR = AXI_ADDR_WIDTH'(REG_BASE + 8);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // live_q keeps every ready low while reset is held and for the first edge after it
  logic                      live_q, live_d;
  logic                      aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BPW-1:0]            wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      rd_res_q, rd_res_d;  // outstanding read targets RESULT
  logic                      fill_sel_q, fill_sel_d;
  logic [IMG_W-1:0]          bank_q [2];
  logic [IMG_W-1:0]          bank_d [2];
  logic                      core_busy_q, core_busy_d, image_valid_q, image_valid_d;
  logic                      res_valid_q, res_valid_d, overrun_q, overrun_d;
  logic [RESULT_BITS-1:0]    result_q, result_d;
  logic                      irq_en_q, irq_en_d, irq_q, irq_d;

  logic                      awready_s, wready_s, arready_s;
  logic                      rd_clr_s, busy_eff_s, ovr_set_s, ovr_clr_s;
  logic [WIDX_W-1:0]         widx_s;

  assign awready_s   = live_q & ~aw_lat_q & ~bvalid_q;
  assign wready_s    = live_q & ~w_lat_q & ~bvalid_q;
  assign arready_s   = live_q & ~rvalid_q;

  assign AWREADY     = awready_s;
  assign WREADY      = wready_s;
  assign ARREADY     = arready_s;
  assign BVALID      = bvalid_q;
  assign BRESP       = bresp_q;
  assign RVALID      = rvalid_q;
  assign RRESP       = rresp_q;
  assign RDATA       = rdata_q;
  assign IMAGE_FLAT  = bank_q[~fill_sel_q];
  assign IMAGE_VALID = image_valid_q;
  assign IRQ         = irq_q;

  // Next-state logic for both AXI channels, the bank store and the status bits
  always_comb begin
    live_d        = 1'b1;
    aw_lat_d      = aw_lat_q;
    awaddr_d      = awaddr_q;
    w_lat_d       = w_lat_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    rvalid_d      = rvalid_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    rd_res_d      = rd_res_q;
    fill_sel_d    = fill_sel_q;
    bank_d        = bank_q;
    core_busy_d   = core_busy_q;
    image_valid_d = image_valid_q;
    res_valid_d   = res_valid_q;
    result_d      = result_q;
    irq_en_d      = irq_en_q;
    ovr_set_s     = 1'b0;
    ovr_clr_s     = 1'b0;
    widx_s        = awaddr_q[BPW_LOG +: WIDX_W];
    rd_clr_s      = rvalid_q & RREADY & rd_res_q;

    // A result read drops RES_VALID unless a new result lands in the same cycle
    if (rd_clr_s) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    // The result is processed before any commit in the same cycle
    busy_eff_s = core_busy_q;
    if (RESULT_IN_VALID) begin
      result_d    = INFERED_DIGIT;
      res_valid_d = 1'b1;
      core_busy_d = 1'b0;
      busy_eff_s  = 1'b0;
      ovr_set_s   = res_valid_q & ~rd_clr_s;
    end else begin
      result_d = result_q;
    end

    if (image_valid_q && IMAGE_READY) begin
      image_valid_d = 1'b0;
    end else begin
      image_valid_d = image_valid_q;
    end

    if (AWVALID && awready_s) begin
      aw_lat_d = 1'b1;
      awaddr_d = AWADDR;
    end else begin
      awaddr_d = awaddr_q;
    end

    if (WVALID && wready_s) begin
      w_lat_d = 1'b1;
      wdata_d = WDATA;
      wstrb_d = WSTRB;
    end else begin
      wdata_d = wdata_q;
    end

    if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    // Execute once address and data are both held
    if (aw_lat_q && w_lat_q) begin
      aw_lat_d = 1'b0;
      w_lat_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      if (awaddr_q < IMG_END) begin
        for (int k = 0; k < PPW; k++) begin
          // a pixel changes only when all of its byte lanes are strobed
          if (&wstrb_q[k*SPP +: SPP]) begin
            bank_d[fill_sel_q][(int'(widx_s) * PPW + k) * PIXEL_BITS +: PIXEL_BITS] =
              wdata_q[k*PIXEL_BITS +: PIXEL_BITS];
          end else begin
            bank_d[fill_sel_q] = bank_d[fill_sel_q];
          end
        end
      end else if (awaddr_q == CTRL_ADDR) begin
        irq_en_d = wdata_q[1];
        if (wdata_q[0] && !busy_eff_s) begin
          fill_sel_d    = ~fill_sel_q;
          core_busy_d   = 1'b1;
          image_valid_d = 1'b1;
        end else if (wdata_q[0]) begin
          ovr_set_s = 1'b1;
          bresp_d   = RESP_SLVERR;
        end else begin
          fill_sel_d = fill_sel_q;
        end
      end else if (awaddr_q == STATUS_ADDR) begin
        ovr_clr_s = wdata_q[2];
      end else if (awaddr_q == RESULT_ADDR) begin
        bresp_d = RESP_OKAY;
      end else begin
        bresp_d = RESP_DECERR;
      end
    end else begin
      bresp_d = bresp_q;
    end

    // A new overrun event wins over a W1C in the same cycle
    overrun_d = (overrun_q & ~ovr_clr_s) | ovr_set_s;

    if (ARVALID && arready_s) begin
      rvalid_d = 1'b1;
      rd_res_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      if (ARADDR < IMG_END) begin
        rresp_d = RESP_OKAY;
      end else if (ARADDR == CTRL_ADDR) begin
        rdata_d = AXI_DATA_WIDTH'({irq_en_q, 1'b0});
      end else if (ARADDR == STATUS_ADDR) begin
        rdata_d = AXI_DATA_WIDTH'({overrun_q, core_busy_q, res_valid_q});
      end else if (ARADDR == RESULT_ADDR) begin
        rdata_d  = AXI_DATA_WIDTH'(result_q);
        rd_res_d = 1'b1;
      end else begin
        rresp_d = RESP_DECERR;
      end
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
      rd_res_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    irq_d = irq_en_q & (res_valid_q | overrun_q);
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      live_q        <= 1'b0;
      aw_lat_q      <= 1'b0;
      awaddr_q      <= '0;
      w_lat_q       <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      rvalid_q      <= 1'b0;
      rresp_q       <= 2'b00;
      rdata_q       <= '0;
      rd_res_q      <= 1'b0;
      fill_sel_q    <= 1'b0;
      bank_q[0]     <= '0;
      bank_q[1]     <= '0;
      core_busy_q   <= 1'b0;
      image_valid_q <= 1'b0;
      res_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      result_q      <= '0;
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      live_q        <= live_d;
      aw_lat_q      <= aw_lat_d;
      awaddr_q      <= awaddr_d;
      w_lat_q       <= w_lat_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      rd_res_q      <= rd_res_d;
      fill_sel_q    <= fill_sel_d;
      bank_q        <= bank_d;
      core_busy_q   <= core_busy_d;
      image_valid_q <= image_valid_d;
      res_valid_q   <= res_valid_d;
      overrun_q     <= overrun_d;
      result_q      <= result_d;
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
    end
  end

endmodule
